// File: rtl/lut_table_loader_pkg.sv
// Shared types and size derivations for the runtime-loadable LUT neuron.
package lut_table_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  function automatic int calc_epw(input int word_bits, input int out_bits);
    return word_bits / out_bits;
  endfunction

  function automatic int calc_nwords(input int in_bits, input int word_bits, input int out_bits);
    return (1 << in_bits) / calc_epw(word_bits, out_bits);
  endfunction

  // Width of a counter/index spanning n values; never below 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_word_ram.sv
// Word-wide table storage: one synchronous write port, asynchronous read (distributed RAM).
module lut_word_ram #(
  parameter int NWORDS    = 16,
  parameter int WORD_BITS = 32,
  parameter int AW        = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [NWORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_table_loader.sv
// Truth-table neuron whose table is streamed in over a config port and then
// served as 1-cycle registered lookups.
module lut_table_loader
  import lut_table_loader_pkg::*;
#(
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 2,
  parameter int WORD_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [WORD_BITS-1:0] cfg_data,
  input  logic                 cfg_last,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_BITS-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_BITS-1:0]  out_data,
  output logic                 loaded,
  output logic                 load_err
);

  localparam int EPW    = calc_epw(WORD_BITS, OUT_BITS);
  localparam int NWORDS = calc_nwords(IN_BITS, WORD_BITS, OUT_BITS);
  localparam int WAW    = cnt_width(NWORDS);
  localparam int SELW   = cnt_width(EPW);

  state_t               state, nstate;
  logic [WAW-1:0]       wcnt;
  logic                 cfg_fire, in_fire, last_word, cfg_ok, done, bad, we;
  logic [WORD_BITS-1:0] rdata;
  logic [EPW-1:0][OUT_BITS-1:0] rword;

  assign cfg_ready = (state == S_LOAD);
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign in_fire   = in_valid && in_ready;
  assign last_word = (wcnt == WAW'(NWORDS - 1));
  assign cfg_ok    = (cfg_last == last_word);
  // A load_start in LOAD wins over a word arriving the same cycle.
  assign done      = cfg_fire && !load_start && cfg_last && last_word;
  assign bad       = cfg_fire && !load_start && !cfg_ok;
  assign we        = cfg_fire && !load_start && cfg_ok && !rst;

  lut_word_ram #(
    .NWORDS   (NWORDS),
    .WORD_BITS(WORD_BITS),
    .AW       (WAW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wcnt),
    .wdata(cfg_data),
    .raddr(in_data[IN_BITS-1:SELW]),
    .rdata(rdata)
  );

  assign rword = rdata;

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (load_start) nstate = S_LOAD;
      S_LOAD: begin
        if (load_start) nstate = S_LOAD;
        else if (done)  nstate = S_RUN;
        else if (bad)   nstate = S_IDLE;
      end
      S_RUN:   if (load_start) nstate = S_LOAD;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= nstate;
      if (load_start) begin
        wcnt   <= '0;
        loaded <= 1'b0;
      end else if (we && !last_word) begin
        wcnt <= wcnt + 1'b1;
      end
      if (done) begin
        loaded   <= 1'b1;
        load_err <= 1'b0;
      end
      if (bad) begin
        loaded   <= 1'b0;
        load_err <= 1'b1;
      end
    end
  end

  // Result register holds under backpressure; a new accept overwrites in the
  // same cycle the old result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= rword[in_data[SELW-1:0]];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed + randomized bench for lut_table_loader with a table-array reference model.
module tb_lut_table_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, cfg_valid, cfg_last, in_valid, out_ready;
  logic [31:0] cfg_data;
  logic [7:0]  in_data;
  logic        cfg_ready, in_ready, out_valid, loaded, load_err;
  logic [1:0]  out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] w   [16];
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  lut_table_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .loaded(loaded), .load_err(load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ent(input int a);
    logic [31:0] t;
    t = mem[a / 16] >> ((a % 16) * 2);
    return t[1:0];
  endfunction

  // Stream the 16 words of w with random bubbles; cfg_last goes on word last_at.
  task automatic do_cfg(input int last_at);
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(3) == 0) begin
        cfg_valid = 1'b0;
        tick();
      end
      cfg_valid = 1'b1;
      cfg_data  = w[i];
      cfg_last  = (i == last_at);
      tick();
      if ((i == last_at) == (i == 15)) mem[i] = w[i];
      if (i == last_at) break;
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic do_load(input int last_at);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    do_cfg(last_at);
  endtask

  task automatic lookup(input string tag, input logic [7:0] a, input logic [1:0] exp);
    in_valid  = 1'b1;
    in_data   = a;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_vld"}, out_valid, 1'b1);
    check(tag, out_data, exp);
  endtask

  task automatic fill_ex2();
    for (int i = 0; i < 16; i++) w[i] = 32'h0;
    w[3] = 32'h0000_0005;
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 'x;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and a lookup attempt with no table.
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_out_data", out_data, 2'b00);
    check("rst_load_err", load_err, 1'b0);
    in_valid = 1'b1; in_data = 8'h31;
    #1;
    check("idle_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_loaded", loaded, 1'b0);

    // Sparse table: only entries 0x30 and 0x31 are 1.
    fill_ex2();
    do_load(15);
    check("ld_loaded", loaded, 1'b1);
    check("ld_err", load_err, 1'b0);
    lookup("lk31", 8'h31, 2'b01);
    lookup("lk32", 8'h32, 2'b00);

    // Random table, back-to-back sweep of every address.
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    do_load(15);
    out_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      in_valid = 1'b1;
      in_data  = 8'(a);
      tick();
      check("sweep_vld", out_valid, 1'b1);
      check("sweep_data", out_data, ent(a));
    end
    in_valid = 1'b0;
    tick();
    check("sweep_drain", out_valid, 1'b0);

    // Backpressure: result holds, no new accept.
    lookup("bp_first", 8'h05, ent(5));
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h06;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      tick();
      check("bp_hold_vld", out_valid, 1'b1);
      check("bp_hold_data", out_data, ent(5));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_next", out_data, ent(6));

    // Random traffic with random backpressure against a one-slot output model.
    begin
      logic ev;
      logic [1:0] ed;
      logic fire;
      ev = 1'b1; ed = ent(6);
      for (int n = 0; n < 300; n++) begin
        in_valid  = ($urandom_range(2) != 0);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(2) != 0);
        #1;
        check("rnd_in_ready", in_ready, !ev || out_ready);
        fire = in_valid && (!ev || out_ready);
        tick();
        if (fire) begin
          ev = 1'b1;
          ed = ent(int'(in_data));
        end else if (out_ready) begin
          ev = 1'b0;
        end
        check("rnd_vld", out_valid, ev);
        if (ev) check("rnd_data", out_data, ed);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
    end

    // Early cfg_last -> error, back to IDLE.
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    do_load(7);
    check("err_flag", load_err, 1'b1);
    check("err_loaded", loaded, 1'b0);
    check("err_idle_cfg_ready", cfg_ready, 1'b0);
    check("err_in_ready", in_ready, 1'b0);
    fill_ex2();
    w[0] = $urandom; w[15] = $urandom;
    do_load(15);
    check("reload_err", load_err, 1'b0);
    check("reload_loaded", loaded, 1'b1);
    lookup("reload_lk31", 8'h31, 2'b01);
    lookup("reload_lk_rand", 8'h0A, ent(10));

    // load_start together with a lookup: served from the old table.
    load_start = 1'b1; in_valid = 1'b1; in_data = 8'h30; out_ready = 1'b1;
    tick();
    load_start = 1'b0; in_valid = 1'b0;
    check("ls_out_vld", out_valid, 1'b1);
    check("ls_out_data", out_data, 2'b01);
    check("ls_in_ready", in_ready, 1'b0);
    check("ls_loaded", loaded, 1'b0);
    check("ls_cfg_ready", cfg_ready, 1'b1);
    for (int i = 0; i < 16; i++) w[i] = 32'hFFFF_FFFF;
    do_cfg(15);
    check("ones_loaded", loaded, 1'b1);
    lookup("ones_lk30", 8'h30, 2'b11);

    // Reset in the middle of a load.
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cfg_valid = 1'b1; cfg_data = w[i]; cfg_last = 1'b0;
      tick();
      mem[i] = w[i];
    end
    cfg_data = w[9]; rst = 1'b1;
    tick();
    rst = 1'b0; cfg_valid = 1'b0;
    check("mrst_cfg_ready", cfg_ready, 1'b0);
    check("mrst_in_ready", in_ready, 1'b0);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_data", out_data, 2'b00);
    check("mrst_loaded", loaded, 1'b0);
    check("mrst_load_err", load_err, 1'b0);
    fill_ex2();
    do_load(15);
    check("post_loaded", loaded, 1'b1);
    lookup("post_lk31", 8'h31, 2'b01);
    lookup("post_lk32", 8'h32, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
